ysyx_24080014_axi_arbiter: RTL and testbench

Two-master, one-slave AXI4-lite arbiter between the core's instruction fetch unit (IFU, read-only) and load/store unit (LSU, read/write) and the shared memory/UART path. It grants exactly one master one complete transaction at a time, forwards that master's channels to the slave and routes the response back. Requests that arrive together are resolved round-robin.

---
 rtl/ysyx_24080014_axi_pkg.sv | 24 ++
 rtl/ysyx_24080014_rr_arb2.sv | 39 +++
 rtl/ysyx_24080014_axi_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_24080014_axi_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080014_axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24080014_axi_pkg: encodings shared by the IFU/LSU AXI4-lite     |
// | arbiter and its round-robin picker.            Revision: 1.0         |
// +----------------------------------------------------------------------+
package ysyx_24080014_axi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Grant IDs double as bit positions in the picker's req/gnt vectors.
  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ysyx_24080014_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24080014_rr_arb2: two-request round-robin picker; a tie goes to |
// | the requester not granted last time.           Revision: 1.0         |
// +----------------------------------------------------------------------+
module ysyx_24080014_rr_arb2
  import ysyx_24080014_axi_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt          = req;
    last_grant_d = last_grant_q;
    if (req == 2'b11) begin
      gnt = (last_grant_q == GNT_LSU) ? 2'b01 : 2'b10;
    end
    if (update && (gnt != 2'b00)) begin
      last_grant_d = gnt[GNT_LSU] ? GNT_LSU : GNT_IFU;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_grant_q <= GNT_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24080014_axi_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24080014_axi_arbiter: IFU/LSU to single-slave AXI4-lite arbiter, |
// | one whole transaction per grant.               Revision: 1.0         |
// +----------------------------------------------------------------------+
module ysyx_24080014_axi_arbiter
  import ysyx_24080014_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  arb_state_e state_q, state_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       arb_en;

  assign req    = {lsu_arvalid | lsu_awvalid, ifu_arvalid};
  assign arb_en = (state_q == IDLE);

  ysyx_24080014_rr_arb2 u_rr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (req),
    .update  (arb_en),
    .gnt     (gnt)
  );

  // Channel steering. The *_done flags stop a channel once it has handshaked,
  // so a master that re-raises a valid early cannot sneak in a second beat.
  always_comb begin
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awaddr    = '0;
    s_awvalid   = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    unique case (state_q)
      IFU_RD: begin
        s_araddr    = ifu_araddr;
        s_arvalid   = ifu_arvalid & ~ar_done_q;
        ifu_arready = s_arready & ~ar_done_q;
        s_rready    = ifu_rready;
        ifu_rvalid  = s_rvalid;
        ifu_rdata   = s_rdata;
        ifu_rresp   = s_rresp;
      end
      LSU_RD: begin
        s_araddr    = lsu_araddr;
        s_arvalid   = lsu_arvalid & ~ar_done_q;
        lsu_arready = s_arready & ~ar_done_q;
        s_rready    = lsu_rready;
        lsu_rvalid  = s_rvalid;
        lsu_rdata   = s_rdata;
        lsu_rresp   = s_rresp;
      end
      LSU_WR: begin
        s_awaddr    = lsu_awaddr;
        s_awvalid   = lsu_awvalid & ~aw_done_q;
        lsu_awready = s_awready & ~aw_done_q;
        s_wdata     = lsu_wdata;
        s_wstrb     = lsu_wstrb;
        s_wvalid    = lsu_wvalid & ~w_done_q;
        lsu_wready  = s_wready & ~w_done_q;
        s_bready    = lsu_bready;
        lsu_bvalid  = s_bvalid;
        lsu_bresp   = s_bresp;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (gnt[GNT_IFU]) begin
          state_d = IFU_RD;
        end else if (gnt[GNT_LSU]) begin
          // A simultaneous LSU read and write resolves read-first.
          state_d = lsu_arvalid ? LSU_RD : LSU_WR;
        end
      end
      IFU_RD, LSU_RD: begin
        if (s_arvalid && s_arready) ar_done_d = 1'b1;
        if (s_rvalid && s_rready)   state_d   = IDLE;
      end
      LSU_WR: begin
        if (s_awvalid && s_awready) aw_done_d = 1'b1;
        if (s_wvalid && s_wready)   w_done_d  = 1'b1;
        if (s_bvalid && s_bready)   state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      ar_done_d = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080014_axi_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_24080014_axi_arbiter: scoreboard bench with a behavioural     |
// | AXI4-lite slave and two master drivers.        Revision: 1.0         |
// +----------------------------------------------------------------------+
module tb_ysyx_24080014_axi_arbiter;
  import ysyx_24080014_axi_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 200;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] ifu_araddr, lsu_araddr, lsu_awaddr, s_araddr, s_awaddr;
  logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [DW-1:0] ifu_rdata, lsu_rdata, lsu_wdata, s_rdata, s_wdata;
  logic [1:0]    ifu_rresp, lsu_rresp, lsu_bresp, s_rresp, s_bresp;
  logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic          lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
  logic          lsu_bvalid, lsu_bready;
  logic [3:0]    lsu_wstrb, s_wstrb;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic          s_awvalid, s_awready, s_wvalid, s_wready;
  logic          s_bvalid, s_bready;

  always #5 aclk = ~aclk;

  ysyx_24080014_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Slave memory model: fixed contents and error decode.
  function automatic logic [31:0] mem_rdata(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0073 : (a ^ 32'hA5A5_0F0F);
  endfunction
  function automatic logic [1:0] mem_rresp(input logic [31:0] a);
    if (a == 32'h0) return DECERR;
    if (a[31:28] == 4'hB) return SLVERR;
    return OKAY;
  endfunction
  function automatic logic [1:0] mem_bresp(input logic [31:0] a);
    return (a[31:28] == 4'hB) ? SLVERR : OKAY;
  endfunction

  // Scoreboard queues: slave-side order {is_write, addr}, and per-master responses.
  logic [32:0] exp_slv_q[$];
  logic [35:0] exp_w_q[$];
  logic [33:0] exp_ifu_r_q[$];
  logic [33:0] exp_lsu_r_q[$];
  logic [1:0]  exp_b_q[$];

  // Handshakes captured at negedge, consumed by the slave after the next posedge.
  logic        hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0;
  logic        saw_awvalid = 0, saw_wvalid = 0;
  logic [31:0] cap_araddr = 0, cap_awaddr = 0;
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
  int          ifu_out = 0, lsu_rd_out = 0, lsu_wr_out = 0, viol = 0;
  logic [31:0] last_ifu_rdata = 0;
  logic [1:0]  last_lsu_rresp = 0;
  int          aw_lat = 0, w_lat = 0;

  task automatic scb_slv(input string tag, input logic [32:0] act);
    if (exp_slv_q.size() == 0) check({tag, "_unexpected"}, act, 33'h0);
    else check(tag, act, exp_slv_q.pop_front());
  endtask

  // Monitor
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      {hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
      ifu_out = 0; lsu_rd_out = 0; lsu_wr_out = 0;
    end else begin
      if (ifu_rvalid && ifu_out == 0) viol++;
      if (lsu_rvalid && lsu_rd_out == 0) viol++;
      if (lsu_bvalid && lsu_wr_out == 0) viol++;
      if ($countones({ifu_arready, lsu_arready, lsu_awready | lsu_wready}) > 1) viol++;
      if (s_arvalid && (s_awvalid || s_wvalid)) viol++;
      hs_ar = s_arvalid && s_arready;
      hs_r  = s_rvalid && s_rready;
      hs_aw = s_awvalid && s_awready;
      hs_w  = s_wvalid && s_wready;
      hs_b  = s_bvalid && s_bready;
      saw_awvalid = s_awvalid;
      saw_wvalid  = s_wvalid;
      if (hs_ar) begin cap_araddr = s_araddr; n_ar++; scb_slv("slv_ar", {1'b0, s_araddr}); end
      if (hs_aw) begin cap_awaddr = s_awaddr; n_aw++; scb_slv("slv_aw", {1'b1, s_awaddr}); end
      if (hs_w) begin
        n_w++;
        if (exp_w_q.size() == 0) check("slv_w_unexpected", {s_wdata, s_wstrb}, 36'h0);
        else check("slv_w", {s_wdata, s_wstrb}, exp_w_q.pop_front());
      end
      if (hs_b) n_b++;
      if (ifu_arvalid && ifu_arready) ifu_out++;
      if (lsu_arvalid && lsu_arready) lsu_rd_out++;
      if (lsu_awvalid && lsu_awready) lsu_wr_out++;
      if (ifu_rvalid && ifu_rready) begin
        ifu_out--; last_ifu_rdata = ifu_rdata;
        if (exp_ifu_r_q.size() == 0) check("ifu_r_unexpected", {ifu_rdata, ifu_rresp}, 34'h0);
        else check("ifu_r", {ifu_rdata, ifu_rresp}, exp_ifu_r_q.pop_front());
      end
      if (lsu_rvalid && lsu_rready) begin
        lsu_rd_out--; last_lsu_rresp = lsu_rresp;
        if (exp_lsu_r_q.size() == 0) check("lsu_r_unexpected", {lsu_rdata, lsu_rresp}, 34'h0);
        else check("lsu_r", {lsu_rdata, lsu_rresp}, exp_lsu_r_q.pop_front());
      end
      if (lsu_bvalid && lsu_bready) begin
        lsu_wr_out--;
        if (exp_b_q.size() == 0) check("lsu_b_unexpected", lsu_bresp, 2'b00);
        else check("lsu_b", lsu_bresp, exp_b_q.pop_front());
      end
    end
  end

  // Behavioural slave: R one cycle after AR, B one cycle after both AW and W.
  initial begin
    int  aw_wait, w_wait;
    logic aw_got, w_got;
    aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0;
    s_arready = 1; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn) begin
        aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0;
        s_rvalid = 0; s_bvalid = 0; s_awready = 0; s_wready = 0;
      end else begin
        if (hs_r) s_rvalid = 0;
        if (hs_ar) begin
          s_rvalid = 1; s_rdata = mem_rdata(cap_araddr); s_rresp = mem_rresp(cap_araddr);
        end
        if (hs_b) s_bvalid = 0;
        if (hs_aw) aw_got = 1;
        if (hs_w)  w_got = 1;
        if (aw_got && w_got && !s_bvalid) begin
          s_bvalid = 1; s_bresp = mem_bresp(cap_awaddr); aw_got = 0; w_got = 0;
        end
        if (hs_aw) aw_wait = 0; else if (saw_awvalid) aw_wait++;
        if (hs_w)  w_wait = 0;  else if (saw_wvalid)  w_wait++;
        s_awready = (aw_wait >= aw_lat);
        s_wready  = (w_wait >= w_lat);
      end
    end
  end

  task automatic ifu_read(input logic [31:0] a, output int ar_cycles);
    int n;
    n = 0;
    @(posedge aclk); #1;
    ifu_araddr = a; ifu_arvalid = 1;
    exp_ifu_r_q.push_back({mem_rdata(a), mem_rresp(a)});
    do begin @(negedge aclk); n++; end while (!(ifu_arvalid && ifu_arready) && n < LIM);
    ar_cycles = n;
    if (n >= LIM) check("ifu_ar_timeout", {ifu_arvalid, ifu_arready}, 2'b11);
    @(posedge aclk); #1;
    ifu_arvalid = 0;
    n = 0;
    do begin @(negedge aclk); n++; end while (!(ifu_rvalid && ifu_rready) && n < LIM);
    if (n >= LIM) check("ifu_r_timeout", {ifu_rvalid, ifu_rready}, 2'b11);
    @(posedge aclk); #1;
  endtask

  // lsu_arvalid stays high across all cnt reads of the stream.
  task automatic lsu_read_stream(input logic [31:0] base, input int cnt);
    int n;
    @(posedge aclk); #1;
    lsu_arvalid = 1;
    for (int i = 0; i < cnt; i++) begin
      lsu_araddr = base + 32'(4 * i);
      exp_lsu_r_q.push_back({mem_rdata(lsu_araddr), mem_rresp(lsu_araddr)});
      n = 0;
      do begin @(negedge aclk); n++; end while (!(lsu_arvalid && lsu_arready) && n < LIM);
      if (n >= LIM) check("lsu_ar_timeout", {lsu_arvalid, lsu_arready}, 2'b11);
      @(posedge aclk); #1;
    end
    lsu_arvalid = 0;
    n = 0;
    while (exp_lsu_r_q.size() != 0 && n < LIM) begin @(negedge aclk); n++; end
    if (n >= LIM) check("lsu_r_timeout", 64'(exp_lsu_r_q.size()), 64'h0);
    @(posedge aclk); #1;
  endtask

  task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    int   n;
    logic aw_ok, w_ok, m_aw, m_w;
    n = 0; aw_ok = 0; w_ok = 0;
    @(posedge aclk); #1;
    lsu_awaddr = a; lsu_awvalid = 1; lsu_wdata = d; lsu_wstrb = st; lsu_wvalid = 1;
    exp_w_q.push_back({d, st});
    exp_b_q.push_back(mem_bresp(a));
    while (!(aw_ok && w_ok) && n < LIM) begin
      @(negedge aclk); n++;
      m_aw = lsu_awvalid && lsu_awready;
      m_w  = lsu_wvalid && lsu_wready;
      @(posedge aclk); #1;
      if (m_aw) begin lsu_awvalid = 0; aw_ok = 1; end
      if (m_w)  begin lsu_wvalid = 0;  w_ok = 1;  end
    end
    if (n >= LIM) check("lsu_aw_w_timeout", {aw_ok, w_ok}, 2'b11);
    n = 0;
    do begin @(negedge aclk); n++; end while (!(lsu_bvalid && lsu_bready) && n < LIM);
    if (n >= LIM) check("lsu_b_timeout", {lsu_bvalid, lsu_bready}, 2'b11);
    @(posedge aclk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, snap_ar, snap_aw, snap_w, snap_b, n;
    ifu_araddr = 0; ifu_arvalid = 0; ifu_rready = 1;
    lsu_araddr = 0; lsu_arvalid = 0; lsu_rready = 1;
    lsu_awaddr = 0; lsu_awvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0; lsu_bready = 1;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_handshake", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, ifu_arready,
                            ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid}, 12'h0);
    check("rst_mrdata", {ifu_rdata, lsu_rdata}, 64'h0);
    check("rst_saddr", {s_araddr, s_awaddr}, 64'h0);
    check("rst_misc", {s_wdata, s_wstrb, ifu_rresp, lsu_rresp, lsu_bresp}, 42'h0);
    check("rst_state", dut.state_q, IDLE);
    check("rst_last_grant", dut.u_rr.last_grant_q, GNT_LSU);
    @(negedge aclk) aresetn = 1;

    // First tie after reset goes to the IFU.
    exp_slv_q.push_back({1'b0, 32'h8000_0100});
    exp_slv_q.push_back({1'b0, 32'h0000_2000});
    fork
      ifu_read(32'h8000_0100, lat);
      lsu_read_stream(32'h0000_2000, 1);
    join

    // IFU alone; leaves last_grant at IFU, so the next tie favours the LSU.
    exp_slv_q.push_back({1'b0, 32'h8000_0000});
    ifu_read(32'h8000_0000, lat);
    check("arb_latency", 64'(lat), 64'd2);
    check("ifu_fetch_data", last_ifu_rdata, 32'h0010_0073);
    check("idle_after_ifu", dut.state_q, IDLE);

    exp_slv_q.push_back({1'b0, 32'h0000_3000});
    exp_slv_q.push_back({1'b0, 32'h8000_0200});
    fork
      ifu_read(32'h8000_0200, lat);
      lsu_read_stream(32'h0000_3000, 1);
    join

    // Write with W accepted two cycles before AW.
    aw_lat = 3; w_lat = 1;
    snap_aw = n_aw; snap_w = n_w; snap_b = n_b;
    exp_slv_q.push_back({1'b1, 32'ha000_03f8});
    lsu_write(32'ha000_03f8, 32'hdead_beef, 4'b0011);
    repeat (3) @(posedge aclk);
    #1;
    check("wr_aw_once", 64'(n_aw - snap_aw), 64'd1);
    check("wr_w_once", 64'(n_w - snap_w), 64'd1);
    check("wr_b_once", 64'(n_b - snap_b), 64'd1);
    aw_lat = 0; w_lat = 0;

    // DECERR forwarded once, no retry.
    snap_ar = n_ar;
    exp_slv_q.push_back({1'b0, 32'h0000_0000});
    lsu_read_stream(32'h0000_0000, 1);
    repeat (4) @(posedge aclk);
    #1;
    check("decerr_ar_once", 64'(n_ar - snap_ar), 64'd1);
    check("decerr_resp", last_lsu_rresp, DECERR);

    // Reset mid-write: AW done, W stalled so B is still pending.
    w_lat = 8;
    exp_slv_q.push_back({1'b1, 32'h1000_0040});
    @(posedge aclk); #1;
    lsu_awaddr = 32'h1000_0040; lsu_awvalid = 1;
    lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hf; lsu_wvalid = 1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!(lsu_awvalid && lsu_awready) && n < LIM);
    if (n >= LIM) check("rstwr_aw_timeout", {lsu_awvalid, lsu_awready}, 2'b11);
    @(posedge aclk); #1;
    lsu_awvalid = 0;
    @(posedge aclk); #2;
    check("rstwr_in_write", dut.state_q, LSU_WR);
    check("rstwr_w_pending", {s_awvalid, s_wvalid}, 2'b01);
    aresetn = 0;
    #1;
    check("rstwr_valids_drop", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                                lsu_awready, lsu_wready, lsu_bvalid, lsu_rvalid, ifu_rvalid}, 10'h0);
    check("rstwr_state", dut.state_q, IDLE);
    lsu_wvalid = 0;
    w_lat = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1;
    check("rstwr_last_grant", dut.u_rr.last_grant_q, GNT_LSU);
    exp_w_q.delete();

    exp_slv_q.push_back({1'b0, 32'h8000_0300});
    exp_slv_q.push_back({1'b0, 32'h0000_4000});
    fork
      ifu_read(32'h8000_0300, lat);
      lsu_read_stream(32'h0000_4000, 1);
    join

    // LSU streams 4 reads; IFU raised during the first is served right after it.
    exp_slv_q.push_back({1'b0, 32'h0000_5000});
    exp_slv_q.push_back({1'b0, 32'h8000_0400});
    exp_slv_q.push_back({1'b0, 32'h0000_5004});
    exp_slv_q.push_back({1'b0, 32'h0000_5008});
    exp_slv_q.push_back({1'b0, 32'h0000_500c});
    fork
      lsu_read_stream(32'h0000_5000, 4);
      begin : b_ifu_mid
        int k;
        k = 0;
        while (!(s_arvalid && s_arready) && k < LIM) begin @(negedge aclk); k++; end
        ifu_read(32'h8000_0400, lat);
      end
    join

    repeat (4) @(posedge aclk);
    #1;
    check("no_crosstalk", 64'(viol), 64'h0);
    check("queues_drained", 64'(exp_slv_q.size() + exp_w_q.size() + exp_ifu_r_q.size()
                                + exp_lsu_r_q.size() + exp_b_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
